// File: rtl/gba_io_fpga_pkg.sv
// Shared definitions for the GBA cartridge bus master: command opcodes,
// controller state encoding and interval timer width.
package gba_io_fpga;

  localparam int TMR_W = 8;

  typedef enum logic [1:0] {
    OP_ROM_READ   = 2'b00,
    OP_SRAM_READ  = 2'b01,
    OP_SRAM_WRITE = 2'b10,
    OP_RSVD       = 2'b11
  } gba_op_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ROM_ADDR,
    ST_ROM_LATCH,
    ST_ROM_RD_LO,
    ST_ROM_RD_HI,
    ST_ROM_END,
    ST_SRAM_SETUP,
    ST_SRAM_STROBE,
    ST_SRAM_HOLD
  } gba_state_e;

endpackage

// File: rtl/gba_cyc_timer.sv
// Load / count-down interval timer. A state that loads N-1 on entry
// sees o_done in its N-th cycle.
module gba_cyc_timer
  import gba_io_fpga::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  // NOTE: sequential state is only ever written with <=, so every register
  // samples its inputs as they were before the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                r_cnt <= '0;
    else if (i_load)         r_cnt <= i_value;
    else if (r_cnt != '0)    r_cnt <= r_cnt - W'(1);
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/gba_bus_master.sv
// GBA cartridge bus master: ROM burst reads over the multiplexed AD bus and
// single-byte SRAM reads/writes, with a valid/ready command and response stream.
module gba_bus_master
  import gba_io_fpga::*;
#(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [23:0] cmd_addr,
  input  logic [7:0]  cmd_len,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_last,
  output logic        busy,
  output logic        gba_rd,
  output logic        gba_wr,
  output logic        gba_cs1,
  output logic        gba_cs2,
  output logic [15:0] gba_adl_o,
  input  logic [15:0] gba_adl_i,
  output logic        gba_adl_oe,
  output logic [7:0]  gba_adh_o,
  input  logic [7:0]  gba_adh_i,
  output logic        gba_adh_oe
);

  localparam logic [TMR_W-1:0] SETUP_LD  = TMR_W'(SETUP_CYC - 1);
  localparam logic [TMR_W-1:0] STROBE_LD = TMR_W'(STROBE_CYC - 1);

  gba_state_e         r_state;
  logic [23:0]        r_addr;
  logic [7:0]         r_left;
  logic               r_is_wr;
  logic               r_relatch;
  logic               r_cmd_ready;
  logic               r_busy;
  logic               r_rsp_valid;
  logic [15:0]        r_rsp_data;
  logic               r_rsp_last;
  logic               r_rd;
  logic               r_wr;
  logic               r_cs1;
  logic               r_cs2;
  logic [15:0]        r_adl_o;
  logic               r_adl_oe;
  logic [7:0]         r_adh_o;
  logic               r_adh_oe;

  gba_op_e            w_op;
  logic               w_cmd_fire;
  logic               w_more;
  logic               w_wrap;
  logic               w_done;
  logic               w_tmr_load;
  logic [TMR_W-1:0]   w_tmr_val;

  assign w_op       = gba_op_e'(cmd_op);
  assign w_cmd_fire = cmd_valid && r_cmd_ready;
  assign w_more     = (r_left != 8'd0);
  // The cartridge's internal address counter is only 16 bits wide.
  assign w_wrap     = &r_addr[15:0];

  // Timer is reloaded on the same edge that enters a timed state.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = SETUP_LD;
    case (r_state)
      ST_IDLE:       w_tmr_load = w_cmd_fire && (w_op != OP_RSVD);
      ST_ROM_ADDR:   w_tmr_load = w_done;
      ST_ROM_LATCH,
      ST_SRAM_SETUP: begin
        w_tmr_load = w_done;
        w_tmr_val  = STROBE_LD;
      end
      ST_ROM_RD_HI: begin
        w_tmr_load = rsp_ready && w_more && !w_wrap;
        w_tmr_val  = STROBE_LD;
      end
      ST_ROM_END:    w_tmr_load = r_relatch;
      default:       ;
    endcase
  end

  gba_cyc_timer #(.W(TMR_W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_tmr_load),
    .i_value (w_tmr_val),
    .o_done  (w_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_left      <= '0;
      r_is_wr     <= 1'b0;
      r_relatch   <= 1'b0;
      r_cmd_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_last  <= 1'b0;
      r_rd        <= 1'b1;
      r_wr        <= 1'b1;
      r_cs1       <= 1'b1;
      r_cs2       <= 1'b1;
      r_adl_o     <= '0;
      r_adl_oe    <= 1'b0;
      r_adh_o     <= '0;
      r_adh_oe    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (w_cmd_fire) begin
            r_addr    <= cmd_addr;
            r_left    <= cmd_len;
            r_is_wr   <= (w_op == OP_SRAM_WRITE);
            r_relatch <= 1'b0;
            r_adl_o   <= cmd_addr[15:0];
            case (w_op)
              OP_ROM_READ: begin
                r_state     <= ST_ROM_ADDR;
                r_busy      <= 1'b1;
                r_cmd_ready <= 1'b0;
                r_adh_o     <= cmd_addr[23:16];
                r_adl_oe    <= 1'b1;
                r_adh_oe    <= 1'b1;
              end
              OP_SRAM_READ, OP_SRAM_WRITE: begin
                r_state     <= ST_SRAM_SETUP;
                r_busy      <= 1'b1;
                r_cmd_ready <= 1'b0;
                r_cs2       <= 1'b0;
                r_adl_oe    <= 1'b1;
                r_adh_oe    <= (w_op == OP_SRAM_WRITE);
                if (w_op == OP_SRAM_WRITE) r_adh_o <= cmd_wdata;
              end
              default: ;  // reserved op: consumed, nothing driven
            endcase
          end
        end
        ST_ROM_ADDR: if (w_done) begin
          r_state <= ST_ROM_LATCH;
          r_cs1   <= 1'b0;
        end
        ST_ROM_LATCH: if (w_done) begin
          r_state  <= ST_ROM_RD_LO;
          r_adl_oe <= 1'b0;
          r_rd     <= 1'b0;
        end
        ST_ROM_RD_LO: if (w_done) begin
          r_state     <= ST_ROM_RD_HI;
          r_rd        <= 1'b1;
          r_rsp_valid <= 1'b1;
          r_rsp_data  <= gba_adl_i;
          r_rsp_last  <= !w_more;
        end
        ST_ROM_RD_HI: if (rsp_ready) begin
          r_rsp_valid <= 1'b0;
          r_rsp_last  <= 1'b0;
          r_addr      <= r_addr + 24'd1;
          if (w_more) r_left <= r_left - 8'd1;
          if (!w_more || w_wrap) begin
            r_state   <= ST_ROM_END;
            r_relatch <= w_more;
            r_cs1     <= 1'b1;
            r_adh_oe  <= 1'b0;
          end else begin
            r_state <= ST_ROM_RD_LO;
            r_rd    <= 1'b0;
          end
        end
        ST_ROM_END: begin
          r_relatch <= 1'b0;
          if (r_relatch) begin
            r_state  <= ST_ROM_ADDR;
            r_adl_o  <= r_addr[15:0];
            r_adh_o  <= r_addr[23:16];
            r_adl_oe <= 1'b1;
            r_adh_oe <= 1'b1;
          end else begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b1;
          end
        end
        ST_SRAM_SETUP: if (w_done) begin
          r_state <= ST_SRAM_STROBE;
          // The AD low bus is never driven while RD is low.
          if (r_is_wr) r_wr <= 1'b0;
          else begin
            r_rd     <= 1'b0;
            r_adl_oe <= 1'b0;
          end
        end
        ST_SRAM_STROBE: if (w_done) begin
          r_state  <= ST_SRAM_HOLD;
          r_rd     <= 1'b1;
          r_wr     <= 1'b1;
          r_adl_oe <= 1'b1;
          if (!r_is_wr) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= {8'h00, gba_adh_i};
            r_rsp_last  <= 1'b1;
          end
        end
        ST_SRAM_HOLD: if (r_is_wr || rsp_ready) begin
          r_state     <= ST_IDLE;
          r_cs2       <= 1'b1;
          r_adl_oe    <= 1'b0;
          r_adh_oe    <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_rsp_last  <= 1'b0;
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign busy       = r_busy;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign rsp_last   = r_rsp_last;
  assign gba_rd     = r_rd;
  assign gba_wr     = r_wr;
  assign gba_cs1    = r_cs1;
  assign gba_cs2    = r_cs2;
  assign gba_adl_o  = r_adl_o;
  assign gba_adl_oe = r_adl_oe;
  assign gba_adh_o  = r_adh_o;
  assign gba_adh_oe = r_adh_oe;

endmodule

// File: tb/tb_gba_bus_master.sv
// Directed bench for gba_bus_master with a behavioural cartridge (ROM returns
// its own 16-bit address, SRAM is a byte array) and a negedge bus monitor.
module tb_gba_bus_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [23:0] cmd_addr;
  logic [7:0]  cmd_len, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_last, busy;
  logic [15:0] rsp_data;
  logic        gba_rd, gba_wr, gba_cs1, gba_cs2;
  logic [15:0] gba_adl_o, gba_adl_i;
  logic        gba_adl_oe, gba_adh_oe;
  logic [7:0]  gba_adh_o, gba_adh_i;

  always #5 clk = ~clk;

  gba_bus_master #(.SETUP_CYC(2), .STROBE_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .busy(busy),
    .gba_rd(gba_rd), .gba_wr(gba_wr), .gba_cs1(gba_cs1), .gba_cs2(gba_cs2),
    .gba_adl_o(gba_adl_o), .gba_adl_i(gba_adl_i), .gba_adl_oe(gba_adl_oe),
    .gba_adh_o(gba_adh_o), .gba_adh_i(gba_adh_i), .gba_adh_oe(gba_adh_oe)
  );

  // Cartridge model
  logic [23:0] rom_ptr = '0;
  logic [7:0]  sram [0:65535];
  logic [23:0] lat_q[$];

  always @(negedge gba_cs1) begin
    rom_ptr = {gba_adh_o, gba_adl_o};
    lat_q.push_back(rom_ptr);
  end
  always @(posedge gba_rd) if (!gba_cs1) rom_ptr[15:0] = rom_ptr[15:0] + 16'd1;
  always @(posedge gba_wr) if (!gba_cs2) sram[gba_adl_o] = gba_adh_o;

  assign gba_adl_i = (!gba_cs1 && !gba_rd) ? rom_ptr[15:0] : 16'hDEAD;
  assign gba_adh_i = (!gba_cs2 && !gba_rd) ? sram[gba_adl_o] : 8'hEE;

  // Bus monitor
  int          rd_run, wr_run, stall_cyc, stall_rd_low, strobe_cyc, addr_cyc, latch_cyc;
  int          viol_rdwr, viol_cs, viol_oe;
  int          rd_pulses[$], wr_pulses[$];
  logic [16:0] rsp_q[$];
  logic [15:0] wr_adl;
  logic [7:0]  wr_adh;
  logic        wr_cs2, wr_adh_oe;

  always @(negedge clk) begin
    if (!gba_rd) rd_run++;
    else if (rd_run != 0) begin rd_pulses.push_back(rd_run); rd_run = 0; end
    if (!gba_wr) begin
      wr_run++;
      if (wr_run == 1) begin
        wr_adl = gba_adl_o; wr_adh = gba_adh_o; wr_cs2 = gba_cs2; wr_adh_oe = gba_adh_oe;
      end
    end else if (wr_run != 0) begin wr_pulses.push_back(wr_run); wr_run = 0; end
    if (rsp_valid && rsp_ready) rsp_q.push_back({rsp_last, rsp_data});
    if (rsp_valid && !rsp_ready) begin
      stall_cyc++;
      if (!gba_rd) stall_rd_low++;
    end
    if (!gba_rd || !gba_wr || !gba_cs1 || !gba_cs2) strobe_cyc++;
    if (gba_cs1 && gba_cs2 && gba_adl_oe && gba_adh_oe) addr_cyc++;
    if (!gba_cs1 && gba_adl_oe) latch_cyc++;
    if (rst) begin
      if (!gba_rd && !gba_wr)     viol_rdwr++;
      if (!gba_cs1 && !gba_cs2)   viol_cs++;
      if (!gba_rd && gba_adl_oe)  viol_oe++;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [16:0] get_rsp(int i);
    return (i < rsp_q.size()) ? rsp_q[i] : 17'h1FFFF;
  endfunction

  function automatic logic [23:0] get_lat(int i);
    return (i < lat_q.size()) ? lat_q[i] : 24'hFFFFFF;
  endfunction

  function automatic int bad_rd_widths(int w);
    int b = 0;
    foreach (rd_pulses[k]) if (rd_pulses[k] != w) b++;
    return b;
  endfunction

  task automatic clear_mon();
    @(posedge clk); #1;
    rd_pulses.delete(); wr_pulses.delete(); rsp_q.delete(); lat_q.delete();
    stall_cyc = 0; stall_rd_low = 0; strobe_cyc = 0; addr_cyc = 0; latch_cyc = 0;
    wr_adl = '0; wr_adh = '0; wr_cs2 = 1'b1; wr_adh_oe = 1'b0;
  endtask

  task automatic send_cmd(input string tag, input logic [1:0] op, input logic [23:0] addr,
                          input logic [7:0] len, input logic [7:0] wd);
    int n = 0;
    @(posedge clk); #1;
    cmd_op = op; cmd_addr = addr; cmd_len = len; cmd_wdata = wd; cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check({tag, "_accept"}, 32'(n < 50), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while ((busy || !cmd_ready) && n < 1000) begin @(negedge clk); n++; end
    check({tag, "_idle"}, 32'(n < 1000), 32'd1);
  endtask

  task automatic check_burst(input string tag, input logic [15:0] first, input int n);
    check({tag, "_nrsp"}, rsp_q.size(), n);
    for (int i = 0; i < n; i++)
      check($sformatf("%s_w%0d", tag, i), get_rsp(i), {(i == n - 1), 16'(first + 16'(i))});
    check({tag, "_nrd"}, rd_pulses.size(), n);
    check({tag, "_rdw"}, bad_rd_widths(4), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_len = '0; cmd_wdata = '0;
    rsp_ready = 1'b1;
    rst = 1'b1;
    #2 rst = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_ctl", {gba_rd, gba_wr, gba_cs1, gba_cs2, gba_adl_oe, gba_adh_oe,
                      rsp_valid, rsp_last, busy, cmd_ready}, 32'b11_1100_0000);
    check("rst_data", {gba_adl_o, gba_adh_o}, 0);
    check("rst_rsp_data", rsp_data, 0);
    rst = 1'b1;
    @(negedge clk);
    check("rel_ready_busy", {cmd_ready, busy}, 2'b10);

    // ROM burst of 4 from 0x000100
    clear_mon();
    send_cmd("rom4", 2'b00, 24'h000100, 8'd3, 8'h00);
    wait_idle("rom4");
    check_burst("rom4", 16'h0100, 4);
    check("rom4_ncs1", lat_q.size(), 1);
    check("rom4_lat", get_lat(0), 24'h000100);
    check("rom4_addr_cyc", addr_cyc, 2);
    check("rom4_latch_cyc", latch_cyc, 2);

    // ROM burst across the 16-bit cartridge counter wrap
    clear_mon();
    send_cmd("wrap", 2'b00, 24'h00FFFE, 8'd3, 8'h00);
    wait_idle("wrap");
    check_burst("wrap", 16'hFFFE, 4);
    check("wrap_ncs1", lat_q.size(), 2);
    check("wrap_lat0", get_lat(0), 24'h00FFFE);
    check("wrap_lat1", get_lat(1), 24'h010000);
    check("wrap_addr_cyc", addr_cyc, 4);

    // SRAM write
    clear_mon();
    send_cmd("swr", 2'b10, 24'h001234, 8'd0, 8'hA5);
    wait_idle("swr");
    check("swr_npulse", wr_pulses.size(), 1);
    check("swr_width", (wr_pulses.size() > 0) ? wr_pulses[0] : -1, 4);
    check("swr_bus", {wr_cs2, wr_adh_oe, wr_adl, wr_adh}, {1'b0, 1'b1, 16'h1234, 8'hA5});
    check("swr_nrsp", rsp_q.size(), 0);
    check("swr_nrd", rd_pulses.size(), 0);
    check("swr_mem", sram[16'h1234], 8'hA5);

    // SRAM read of the same byte
    clear_mon();
    send_cmd("srd", 2'b01, 24'h001234, 8'd0, 8'h00);
    wait_idle("srd");
    check("srd_nrsp", rsp_q.size(), 1);
    check("srd_rsp", get_rsp(0), {1'b1, 16'h00A5});
    check("srd_nrd", rd_pulses.size(), 1);
    check("srd_rdw", bad_rd_widths(4), 0);
    check("srd_nwr", wr_pulses.size(), 0);

    // ROM burst with a 10-cycle back-pressure stall on word 2
    clear_mon();
    send_cmd("stall", 2'b00, 24'h000200, 8'd3, 8'h00);
    n = 0;
    while (rsp_q.size() < 1 && n < 200) begin @(negedge clk); n++; end
    @(posedge clk); #1 rsp_ready = 1'b0;
    n = 0;
    while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
    check("stall_w2_seen", 32'(n < 200), 32'd1);
    repeat (9) @(negedge clk);
    @(posedge clk); #1 rsp_ready = 1'b1;
    wait_idle("stall");
    check_burst("stall", 16'h0200, 4);
    check("stall_cyc", stall_cyc, 10);
    check("stall_rd_low", stall_rd_low, 0);

    // Reset in the middle of ROM_RD_LO, then a reserved op
    clear_mon();
    send_cmd("rrst", 2'b00, 24'h000300, 8'd5, 8'h00);
    n = 0;
    @(negedge clk);
    while (gba_rd && n < 200) begin @(negedge clk); n++; end
    check("rrst_rd_seen", 32'(n < 200), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("rrst_ctl", {gba_rd, gba_wr, gba_cs1, gba_cs2, gba_adl_oe, gba_adh_oe,
                       rsp_valid, busy, cmd_ready}, 32'b1_1110_0000);
    rst = 1'b1;
    @(negedge clk);
    check("rrst_ready", {cmd_ready, busy}, 2'b10);
    clear_mon();
    repeat (20) @(negedge clk);
    check("rrst_nrsp", rsp_q.size(), 0);
    check("rrst_quiet", strobe_cyc, 0);

    clear_mon();
    send_cmd("rsvd", 2'b11, 24'h000400, 8'd0, 8'h00);
    @(negedge clk);
    check("rsvd_ready", {cmd_ready, busy}, 2'b10);
    repeat (10) @(negedge clk);
    check("rsvd_quiet", strobe_cyc, 0);
    check("rsvd_nrsp", rsp_q.size(), 0);

    check("inv_rd_wr", viol_rdwr, 0);
    check("inv_cs", viol_cs, 0);
    check("inv_adl_oe", viol_oe, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
